uart_tx_fifo_sched: RTL and testbench
=====================================

Name: uart_tx_fifo_sched

Overview:
Read-side scheduler between the async FIFO read port and the UART transmitter, in the UART read/TX clock domain.
- Pops one word whenever the FIFO is non-empty, the block is enabled and the transmitter is idle.
- Presents the word to UART TX with a single-cycle valid strobe and tracks the busy handshake until the frame completes.
- Enforces a configurable inter-frame gap, detects a transmitter that never starts, and counts completed frames.

Parameters:
- D_SIZE, 8, data word width (matches FIFO D_SIZE).
- TIMEOUT, 16, cycles allowed between valid strobe and i_tx_busy rising; legal range 2..255.
- GAP_CYC, 2, idle cycles inserted after each frame; 0 = no gap.
- CNT_W, 8, width of completed-frame counter.

Ports:
- i_clk  in  1  read/TX domain clock; single clock.
- i_rstn  in  1  asynchronous, active-low reset.
- i_en  in  1  scheduler enable; sampled only in IDLE.
- i_fifo_empty  in  1  FIFO empty flag (read domain).
- i_fifo_rdata  in  D_SIZE  FIFO read data; show-ahead, valid while empty=0.
- o_fifo_rinc  out  1  FIFO read increment; one-cycle pulse per pop.
- o_tx_data  out  D_SIZE  word presented to UART TX; held stable until next pop.
- o_tx_valid  out  1  one-cycle data-valid strobe to UART TX.
- i_tx_busy  in  1  UART TX busy; high for the duration of a frame.
- i_clr_timeout  in  1  clears sticky o_timeout.
- o_timeout  out  1  sticky: TX failed to assert busy within TIMEOUT cycles.
- o_frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W.
- o_active  out  1  high whenever state != IDLE.

Behaviour:
Reset (async assert, sync release):
- state=IDLE; all outputs 0, including o_tx_data, o_frame_cnt and o_timeout.
- Internal counter cleared.

Output timing:
- All outputs come from flops: either registered directly or decoded from a one-hot state register. No combinational path from input to output.

States and transitions:
- IDLE: if i_en=1 and i_fifo_empty=0 at a clock edge, then o_tx_data <= i_fifo_rdata and go to LOAD. Otherwise stay.
- LOAD (exactly 1 cycle): o_fifo_rinc=1 and o_tx_valid=1 together; counter cleared; then go to WAIT_BUSY. Exactly one pop per frame; no back-to-back pops.
- WAIT_BUSY: counter increments each cycle.
  - If i_tx_busy=1, go to WAIT_DONE. Busy wins over timeout when both occur in the same cycle.
  - Otherwise, when counter reaches TIMEOUT-1, set o_timeout and go to IDLE. The frame is dropped, the word is not re-popped and o_frame_cnt does not increment.
- WAIT_DONE: stay while i_tx_busy=1. On i_tx_busy=0:
  - o_frame_cnt increments, wrapping 2^CNT_W-1 -> 0.
  - Go to GAP with counter cleared if GAP_CYC>0; otherwise go to IDLE.
- GAP: counter increments; after exactly GAP_CYC cycles in GAP, go to IDLE.

Latency:
- FIFO non-empty sampled in IDLE -> o_tx_valid on the next cycle.
- Minimum period between valid strobes = 1 (LOAD) + busy-rise latency + frame length + 1 + GAP_CYC + 1 (IDLE).

Boundaries:
- i_en deasserted mid-frame: the in-flight frame completes normally; no new pop.
- i_fifo_empty rising after the IDLE decision: ignored. The word was already captured, and the FIFO guarantees the entry exists.
- i_tx_busy already high in IDLE: pop is still permitted, and WAIT_BUSY exits on the first cycle.
- o_timeout set and i_clr_timeout in the same cycle: set wins. Clear otherwise takes effect the next cycle.
- Reset mid-frame: immediate return to IDLE with no o_fifo_rinc. A pulse in flight is truncated by the asynchronous clear.
- Internal counter width: clog2(max(TIMEOUT, GAP_CYC, 2)) + 1 bits; it must not wrap before its terminal count.

Decomposition:
- Package uart_sched_pkg holds:
  - one-hot state localparams: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP;
  - the counter-width function.
- One natural sub-module: sched_cnt, a clear/enable up-counter with a terminal-count compare, shared by WAIT_BUSY and GAP.
- The FSM, data register and frame counter stay in the top module.

Test Plan:
1. FIFO holds 0xA5, i_en=1, TX model raises busy 2 cycles after valid and holds it 10 cycles:
   - o_fifo_rinc and o_tx_valid each pulse exactly 1 cycle, together, 1 cycle after empty=0 is sampled;
   - o_tx_data=0xA5;
   - o_frame_cnt goes 0->1;
   - next pop no earlier than 2 + 1 cycles after busy falls (GAP_CYC=2).
2. Three words 0x11, 0x22, 0x33 queued: three strictly sequential frames, one rinc each, data in order, o_frame_cnt=3, then IDLE with o_active=0.
3. TX model never asserts busy: o_timeout rises exactly 16 cycles after the valid strobe, state returns to IDLE, o_frame_cnt unchanged. Pulse i_clr_timeout -> o_timeout=0 on the next cycle.
4. i_en dropped one cycle after LOAD with 2 words queued: the current frame completes, no further rinc while i_en=0; re-enable -> second word sent.
5. Assert i_rstn=0 during WAIT_DONE: all outputs 0 immediately; after release, no spurious rinc until a fresh IDLE decision.
6. CNT_W=2, 5 frames: o_frame_cnt reads 1, 2, 3, 0, 1. Repeat with GAP_CYC=0: IDLE follows WAIT_DONE directly.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART TX read-side scheduler: one-hot state
// encoding and the sizing rule for the shared wait/gap counter.
package uart_sched_pkg;

  localparam int ST_W     = 5;

  // Bit positions inside the one-hot state vector
  localparam int IDLE_B   = 0;
  localparam int LOAD_B   = 1;
  localparam int WBUSY_B  = 2;
  localparam int WDONE_B  = 3;
  localparam int GAP_B    = 4;

  typedef enum logic [ST_W-1:0] {
    IDLE      = 5'b00001,
    LOAD      = 5'b00010,
    WAIT_BUSY = 5'b00100,
    WAIT_DONE = 5'b01000,
    GAP       = 5'b10000
  } sched_state_e;

  // One spare bit above clog2 of the largest terminal count, so the counter
  // can never wrap before it reaches either the timeout or the gap length.
  function automatic int sched_cnt_width(input int timeout_cyc, input int gap_cyc);
    int m;
    m = (timeout_cyc > gap_cyc) ? timeout_cyc : gap_cyc;
    if (m < 2) m = 2;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sched_cnt.sv
// Clear/enable up-counter with a terminal-count flag. The flag is raised in
// the cycle whose enabled increment lands on term, so the owner can act on
// the same clock edge that the count is reached.
module sched_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  assign cnt_next = cnt_reg + W'(1);
  assign tc       = en && (cnt_next == term);

  // Count register: clear has priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_sched.sv
// Read-side scheduler between the FIFO read port and the UART transmitter.
// Pops one word per frame, strobes it into the transmitter, follows the busy
// handshake, inserts an inter-frame gap and flags a transmitter that never
// starts. Every output is a flop or a single bit of the one-hot state.
module uart_tx_fifo_sched
  import uart_sched_pkg::*;
#(
  parameter int D_SIZE  = 8,
  parameter int TIMEOUT = 16,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_fifo_empty,
  input  logic [D_SIZE-1:0] i_fifo_rdata,
  output logic              o_fifo_rinc,
  output logic [D_SIZE-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_busy,
  input  logic              i_clr_timeout,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic              o_active
);

  localparam int            CW       = sched_cnt_width(TIMEOUT, GAP_CYC);
  // WAIT_BUSY gives up when the count reaches TIMEOUT-1; GAP leaves after
  // GAP_CYC cycles. Both use the same "count reached on this edge" flag.
  localparam logic [CW-1:0] TO_TERM  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_TERM = CW'(GAP_CYC);

  sched_state_e      state_reg;
  sched_state_e      state_next;
  logic [D_SIZE-1:0] tx_data_reg;
  logic [CNT_W-1:0]  frame_cnt_reg;
  logic              timeout_reg;

  logic              load_data;
  logic              frame_done;
  logic              timeout_set;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_tc;
  logic [CW-1:0]     cnt_term;

  assign cnt_term = state_reg[GAP_B] ? GAP_TERM : TO_TERM;

  sched_cnt #(
    .W (CW)
  ) u_cnt (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term),
    .tc    (cnt_tc)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    state_next  = state_reg;
    load_data   = 1'b0;
    frame_done  = 1'b0;
    timeout_set = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (i_en && !i_fifo_empty) begin
          load_data  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        cnt_clr    = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_en = 1'b1;
        // busy is checked first so a late start still counts as a frame
        if (i_tx_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_tc) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          frame_done = 1'b1;
          if (GAP_CYC > 0) begin
            cnt_clr    = 1'b1;
            state_next = GAP;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word captured at the IDLE decision and held until the next pop
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tx_data_reg <= '0;
    end else if (load_data) begin
      tx_data_reg <= i_fifo_rdata;
    end
  end

  // Completed-frame counter, wraps naturally
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      frame_cnt_reg <= '0;
    end else if (frame_done) begin
      frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
    end
  end

  // Sticky timeout flag: a new timeout beats a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      timeout_reg <= 1'b0;
    end else if (timeout_set) begin
      timeout_reg <= 1'b1;
    end else if (i_clr_timeout) begin
      timeout_reg <= 1'b0;
    end
  end

  assign o_fifo_rinc = state_reg[LOAD_B];
  assign o_tx_valid  = state_reg[LOAD_B];
  assign o_active    = ~state_reg[IDLE_B];
  assign o_tx_data   = tx_data_reg;
  assign o_frame_cnt = frame_cnt_reg;
  assign o_timeout   = timeout_reg;

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Directed bench for uart_tx_fifo_sched: a cycle table on the default
// instance, hand-written reset sequence, and two narrow-counter instances
// (with and without an inter-frame gap).
module tb_uart_tx_fifo_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       en, empty, busy, clr;
  logic [7:0] rdata;
  logic       rinc, valid, timeout, active;
  logic [7:0] tx_data, frame_cnt;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo_sched #(
    .D_SIZE(8), .TIMEOUT(16), .GAP_CYC(2), .CNT_W(8)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_fifo_empty(empty),
    .i_fifo_rdata(rdata), .o_fifo_rinc(rinc), .o_tx_data(tx_data),
    .o_tx_valid(valid), .i_tx_busy(busy), .i_clr_timeout(clr),
    .o_timeout(timeout), .o_frame_cnt(frame_cnt), .o_active(active)
  );

  // Narrow frame counter instances: index 0 has GAP_CYC=2, index 1 has none
  logic       s_en [2];
  logic       s_empty [2];
  logic       s_busy [2];
  logic [7:0] s_rdata [2];
  logic       s_rinc [2];
  logic       s_valid [2];
  logic       s_timeout [2];
  logic       s_active [2];
  logic [7:0] s_data [2];
  logic [1:0] s_cnt [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_small
      uart_tx_fifo_sched #(
        .D_SIZE(8), .TIMEOUT(16), .GAP_CYC((gi == 0) ? 2 : 0), .CNT_W(2)
      ) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(s_en[gi]), .i_fifo_empty(s_empty[gi]),
        .i_fifo_rdata(s_rdata[gi]), .o_fifo_rinc(s_rinc[gi]), .o_tx_data(s_data[gi]),
        .o_tx_valid(s_valid[gi]), .i_tx_busy(s_busy[gi]), .i_clr_timeout(1'b0),
        .o_timeout(s_timeout[gi]), .o_frame_cnt(s_cnt[gi]), .o_active(s_active[gi])
      );
    end
  endgenerate

  typedef struct {
    int         rep;
    logic       en, empty;
    logic [7:0] rdata;
    logic       busy, clr;
    logic       rinc, valid;
    logic [7:0] data;
    logic       to;
    logic [7:0] cnt;
    logic       act;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(input int rep, input logic en_i, input logic empty_i,
                             input logic [7:0] rdata_i, input logic busy_i, input logic clr_i,
                             input logic rinc_e, input logic valid_e, input logic [7:0] data_e,
                             input logic to_e, input logic [7:0] cnt_e, input logic act_e);
    vec_t r;
    r.rep = rep; r.en = en_i; r.empty = empty_i; r.rdata = rdata_i;
    r.busy = busy_i; r.clr = clr_i; r.rinc = rinc_e; r.valid = valid_e;
    r.data = data_e; r.to = to_e; r.cnt = cnt_e; r.act = act_e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end else begin
      $display("ok   %s: %0h", name, act_v);
    end
  endtask

  task automatic small_frame(input int k, input logic [7:0] word,
                             input logic [1:0] exp_cnt, input int gap);
    s_en[k] = 1'b1; s_empty[k] = 1'b0; s_rdata[k] = word; s_busy[k] = 1'b0;
    @(negedge clk);
    check($sformatf("small%0d_pop_%0h", k, word),
          {22'd0, s_rinc[k], s_valid[k], s_data[k]}, {22'd0, 1'b1, 1'b1, word});
    s_empty[k] = 1'b1; s_busy[k] = 1'b1;
    repeat (2) @(negedge clk);
    s_busy[k] = 1'b0;
    @(negedge clk);
    check($sformatf("small%0d_cnt", k), {30'd0, s_cnt[k]}, {30'd0, exp_cnt});
    check($sformatf("small%0d_active_after_done", k), {31'd0, s_active[k]},
          {31'd0, (gap != 0)});
    repeat (gap) @(negedge clk);
    check($sformatf("small%0d_idle", k), {31'd0, s_active[k]}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; empty = 1'b1; rdata = 8'h00; busy = 1'b0; clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_en[k] = 1'b0; s_empty[k] = 1'b1; s_busy[k] = 1'b0; s_rdata[k] = 8'h00;
    end

    //              rep en em rdata  bu cl | ri va data   to cnt   act
    // idle: disabled, then empty
    tbl.push_back(v(3,  0, 0, 8'hEE, 0, 0,   0, 0, 8'h00, 0, 8'd0, 0));
    tbl.push_back(v(2,  1, 1, 8'hEE, 0, 0,   0, 0, 8'h00, 0, 8'd0, 0));
    // single word A5, busy 2 cycles after valid for 10 cycles, next word waiting
    tbl.push_back(v(1,  1, 0, 8'hA5, 0, 0,   1, 1, 8'hA5, 0, 8'd0, 1));
    tbl.push_back(v(2,  1, 1, 8'hA5, 0, 0,   0, 0, 8'hA5, 0, 8'd0, 1));
    tbl.push_back(v(10, 1, 1, 8'hA5, 1, 0,   0, 0, 8'hA5, 0, 8'd0, 1));
    tbl.push_back(v(2,  1, 0, 8'h11, 0, 0,   0, 0, 8'hA5, 0, 8'd1, 1));
    tbl.push_back(v(1,  1, 0, 8'h11, 0, 0,   0, 0, 8'hA5, 0, 8'd1, 0));
    // three queued words 11, 22, 33
    tbl.push_back(v(1,  1, 0, 8'h11, 0, 0,   1, 1, 8'h11, 0, 8'd1, 1));
    tbl.push_back(v(4,  1, 0, 8'h22, 1, 0,   0, 0, 8'h11, 0, 8'd1, 1));
    tbl.push_back(v(2,  1, 0, 8'h22, 0, 0,   0, 0, 8'h11, 0, 8'd2, 1));
    tbl.push_back(v(1,  1, 0, 8'h22, 0, 0,   0, 0, 8'h11, 0, 8'd2, 0));
    tbl.push_back(v(1,  1, 0, 8'h22, 0, 0,   1, 1, 8'h22, 0, 8'd2, 1));
    tbl.push_back(v(4,  1, 0, 8'h33, 1, 0,   0, 0, 8'h22, 0, 8'd2, 1));
    tbl.push_back(v(2,  1, 0, 8'h33, 0, 0,   0, 0, 8'h22, 0, 8'd3, 1));
    tbl.push_back(v(1,  1, 0, 8'h33, 0, 0,   0, 0, 8'h22, 0, 8'd3, 0));
    tbl.push_back(v(1,  1, 0, 8'h33, 0, 0,   1, 1, 8'h33, 0, 8'd3, 1));
    tbl.push_back(v(4,  1, 1, 8'h33, 1, 0,   0, 0, 8'h33, 0, 8'd3, 1));
    tbl.push_back(v(2,  1, 1, 8'h33, 0, 0,   0, 0, 8'h33, 0, 8'd4, 1));
    tbl.push_back(v(4,  1, 1, 8'h33, 0, 0,   0, 0, 8'h33, 0, 8'd4, 0));
    // enable dropped during the frame with a second word queued
    tbl.push_back(v(1,  1, 0, 8'h44, 0, 0,   1, 1, 8'h44, 0, 8'd4, 1));
    tbl.push_back(v(1,  0, 0, 8'h55, 0, 0,   0, 0, 8'h44, 0, 8'd4, 1));
    tbl.push_back(v(2,  0, 0, 8'h55, 1, 0,   0, 0, 8'h44, 0, 8'd4, 1));
    tbl.push_back(v(2,  0, 0, 8'h55, 0, 0,   0, 0, 8'h44, 0, 8'd5, 1));
    tbl.push_back(v(5,  0, 0, 8'h55, 0, 0,   0, 0, 8'h44, 0, 8'd5, 0));
    tbl.push_back(v(1,  1, 0, 8'h55, 0, 0,   1, 1, 8'h55, 0, 8'd5, 1));
    tbl.push_back(v(2,  1, 1, 8'h55, 1, 0,   0, 0, 8'h55, 0, 8'd5, 1));
    tbl.push_back(v(2,  1, 1, 8'h55, 0, 0,   0, 0, 8'h55, 0, 8'd6, 1));
    tbl.push_back(v(1,  1, 1, 8'h55, 0, 0,   0, 0, 8'h55, 0, 8'd6, 0));
    // busy already high at the IDLE decision: WAIT_BUSY left on its first cycle
    tbl.push_back(v(1,  1, 0, 8'h66, 1, 0,   1, 1, 8'h66, 0, 8'd6, 1));
    tbl.push_back(v(2,  1, 1, 8'h66, 1, 0,   0, 0, 8'h66, 0, 8'd6, 1));
    tbl.push_back(v(2,  1, 1, 8'h66, 0, 0,   0, 0, 8'h66, 0, 8'd7, 1));
    tbl.push_back(v(1,  1, 1, 8'h66, 0, 0,   0, 0, 8'h66, 0, 8'd7, 0));
    // busy rises on the same edge the timeout count is reached: busy wins
    tbl.push_back(v(1,  1, 0, 8'h77, 0, 0,   1, 1, 8'h77, 0, 8'd7, 1));
    tbl.push_back(v(15, 1, 1, 8'h77, 0, 0,   0, 0, 8'h77, 0, 8'd7, 1));
    tbl.push_back(v(1,  1, 1, 8'h77, 1, 0,   0, 0, 8'h77, 0, 8'd7, 1));
    tbl.push_back(v(2,  1, 1, 8'h77, 0, 0,   0, 0, 8'h77, 0, 8'd8, 1));
    tbl.push_back(v(1,  1, 1, 8'h77, 0, 0,   0, 0, 8'h77, 0, 8'd8, 0));
    // transmitter never starts: timeout 16 cycles after valid, set beats clear
    tbl.push_back(v(1,  1, 0, 8'h88, 0, 0,   1, 1, 8'h88, 0, 8'd8, 1));
    tbl.push_back(v(15, 1, 1, 8'h88, 0, 0,   0, 0, 8'h88, 0, 8'd8, 1));
    tbl.push_back(v(1,  1, 1, 8'h88, 0, 1,   0, 0, 8'h88, 1, 8'd8, 0));
    tbl.push_back(v(2,  1, 1, 8'h88, 0, 0,   0, 0, 8'h88, 1, 8'd8, 0));
    tbl.push_back(v(1,  1, 1, 8'h88, 0, 1,   0, 0, 8'h88, 0, 8'd8, 0));

    repeat (2) @(negedge clk);
    check("reset_main", {12'd0, rinc, valid, tx_data, timeout, frame_cnt, active}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_small%0d", k),
            {26'd0, s_rinc[k], s_valid[k], s_timeout[k], s_active[k], s_cnt[k]}, 32'd0);
    end
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        en = tbl[i].en; empty = tbl[i].empty; rdata = tbl[i].rdata;
        busy = tbl[i].busy; clr = tbl[i].clr;
        @(negedge clk);
        check($sformatf("vec%0d.%0d", i, r),
              {12'd0, rinc, valid, tx_data, timeout, frame_cnt, active},
              {12'd0, tbl[i].rinc, tbl[i].valid, tbl[i].data, tbl[i].to,
               tbl[i].cnt, tbl[i].act});
      end
    end

    // reset while the transmitter is busy
    en = 1'b1; empty = 1'b0; rdata = 8'h99; busy = 1'b0; clr = 1'b0;
    @(negedge clk);
    check("rst_seq_pop", {22'd0, rinc, valid, tx_data}, {22'd0, 1'b1, 1'b1, 8'h99});
    empty = 1'b1; busy = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_seq_in_frame", {31'd0, active}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_clear", {12'd0, rinc, valid, tx_data, timeout, frame_cnt, active}, 32'd0);
    busy = 1'b0;
    @(negedge clk);
    check("rst_held", {30'd0, rinc, active}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_release_no_pop", {30'd0, rinc, active}, 32'd0);
    empty = 1'b0; rdata = 8'h5A;
    @(negedge clk);
    check("rst_fresh_pop", {14'd0, rinc, valid, tx_data, frame_cnt},
          {14'd0, 1'b1, 1'b1, 8'h5A, 8'd0});
    empty = 1'b1; en = 1'b0;

    // narrow counter wraps: 1, 2, 3, 0, 1
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 5; f++) begin
        small_frame(k, 8'(8'h10 + f), 2'((f + 1) % 4), (k == 0) ? 2 : 0);
      end
      s_en[k] = 1'b0;
      check($sformatf("small%0d_no_timeout", k), {31'd0, s_timeout[k]}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
